// File: rtl/riscv_regfile_access.sv
// Register-file access initiator: decodes rs1/rs2/rd, fetches operands through a registered-read
// register file and forwards writebacks. Define WB_BYPASS_EN to forward conflicting writes instead of re-reading.
module riscv_regfile_access #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned REG_DEPTH = 32,
    parameter int unsigned ADDR_W    = $clog2(REG_DEPTH)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Instr_valid,
    output logic                 Instr_ready,
    input  logic [31:0]          Instr,
    output logic                 Op_valid,
    input  logic                 Op_ready,
    output logic [REG_WIDTH-1:0] Op_A,
    output logic [REG_WIDTH-1:0] Op_B,
    output logic [ADDR_W-1:0]    Op_rd,
    input  logic                 Wb_valid,
    input  logic [ADDR_W-1:0]    Wb_addr,
    input  logic [REG_WIDTH-1:0] Wb_data,
    output logic [ADDR_W-1:0]    Rf_Addr1,
    output logic [ADDR_W-1:0]    Rf_Addr2,
    output logic [ADDR_W-1:0]    Rf_Addr3,
    output logic                 Rf_Regwrite,
    output logic [REG_WIDTH-1:0] Rf_Inputs,
    input  logic [REG_WIDTH-1:0] Rf_RD1,
    input  logic [REG_WIDTH-1:0] Rf_RD2
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    r_addr1;
    logic [ADDR_W-1:0]    r_addr2;
    logic [ADDR_W-1:0]    r_rd;
    logic [REG_WIDTH-1:0] r_op_a;
    logic [REG_WIDTH-1:0] r_op_b;
    logic                 r_op_valid;
    logic                 r_fwd1;
    logic                 r_fwd2;
`ifdef WB_BYPASS_EN
    logic [REG_WIDTH-1:0] r_fwd_d1;
    logic [REG_WIDTH-1:0] r_fwd_d2;
`endif
    logic                 w_regwrite;
    logic                 w_conf1;
    logic                 w_conf2;
    logic                 w_accept;
    logic                 w_capture;
    logic [REG_WIDTH-1:0] w_op_a;
    logic [REG_WIDTH-1:0] w_op_b;
    logic                 w_unused_instr;

    assign w_regwrite  = Wb_valid && (Wb_addr != '0);
    assign Rf_Regwrite = w_regwrite;
    assign Rf_Addr3    = Wb_addr;
    assign Rf_Inputs   = Wb_data;

    assign Rf_Addr1 = r_addr1;
    assign Rf_Addr2 = r_addr2;
    assign Op_rd    = r_rd;
    assign Op_A     = r_op_a;
    assign Op_B     = r_op_b;
    assign Op_valid = r_op_valid;

    assign w_unused_instr = ^{Instr[31:25], Instr[14:12], Instr[6:0]};

    // A write to a latched nonzero source register makes the in-flight read stale.
    assign w_conf1 = w_regwrite && (Wb_addr == r_addr1) && (r_addr1 != '0);
    assign w_conf2 = w_regwrite && (Wb_addr == r_addr2) && (r_addr2 != '0);

    assign Instr_ready = (r_state == IDLE) && Rst;
    assign w_accept    = Instr_valid && Instr_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_op_a      = '0;
        w_op_b      = '0;
`ifdef WB_BYPASS_EN
        if (r_addr1 != '0) w_op_a = w_conf1 ? Wb_data : (r_fwd1 ? r_fwd_d1 : Rf_RD1);
        if (r_addr2 != '0) w_op_b = w_conf2 ? Wb_data : (r_fwd2 ? r_fwd_d2 : Rf_RD2);
`else
        if (r_addr1 != '0) w_op_a = Rf_RD1;
        if (r_addr2 != '0) w_op_b = Rf_RD2;
`endif
        case (r_state)
            IDLE:  if (w_accept) w_state_nxt = ISSUE;
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
`ifdef WB_BYPASS_EN
                w_capture   = 1'b1;
                w_state_nxt = HOLD;
`else
                // ISSUE conflicts are remembered in the forward flags and retried here.
                if (r_fwd1 || r_fwd2 || w_conf1 || w_conf2) begin
                    w_state_nxt = ISSUE;
                end else begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end
`endif
            end
            HOLD:    if (Op_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= IDLE;
            r_addr1    <= '0;
            r_addr2    <= '0;
            r_rd       <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_valid <= 1'b0;
            r_fwd1     <= 1'b0;
            r_fwd2     <= 1'b0;
`ifdef WB_BYPASS_EN
            r_fwd_d1   <= '0;
            r_fwd_d2   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr1 <= ADDR_W'(Instr[19:15]);
                r_addr2 <= ADDR_W'(Instr[24:20]);
                r_rd    <= ADDR_W'(Instr[11:7]);
            end
            if (r_state == ISSUE) begin
                r_fwd1   <= w_conf1;
                r_fwd2   <= w_conf2;
`ifdef WB_BYPASS_EN
                r_fwd_d1 <= Wb_data;
                r_fwd_d2 <= Wb_data;
`endif
            end
            if (w_capture) begin
                r_op_a     <= w_op_a;
                r_op_b     <= w_op_b;
                r_op_valid <= 1'b1;
            end else if ((r_state == HOLD) && Op_ready) begin
                r_op_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_regfile_access.sv
// Bench for riscv_regfile_access: registered-read register file environment plus an
// architectural-register reference model; honours WB_BYPASS_EN for expected latency.
module tb_riscv_regfile_access;
    localparam int unsigned W  = 32;
    localparam int unsigned D  = 32;
    localparam int unsigned AW = 5;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Instr_valid;
    logic          Instr_ready;
    logic [31:0]   Instr;
    logic          Op_valid;
    logic          Op_ready;
    logic [W-1:0]  Op_A;
    logic [W-1:0]  Op_B;
    logic [AW-1:0] Op_rd;
    logic          Wb_valid;
    logic [AW-1:0] Wb_addr;
    logic [W-1:0]  Wb_data;
    logic [AW-1:0] Rf_Addr1;
    logic [AW-1:0] Rf_Addr2;
    logic [AW-1:0] Rf_Addr3;
    logic          Rf_Regwrite;
    logic [W-1:0]  Rf_Inputs;
    logic [W-1:0]  Rf_RD1;
    logic [W-1:0]  Rf_RD2;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] rf_mem [D];
    logic [W-1:0] arch   [D];

    riscv_regfile_access #(.REG_WIDTH(W), .REG_DEPTH(D)) dut (
        .Clk(Clk), .Rst(Rst),
        .Instr_valid(Instr_valid), .Instr_ready(Instr_ready), .Instr(Instr),
        .Op_valid(Op_valid), .Op_ready(Op_ready), .Op_A(Op_A), .Op_B(Op_B), .Op_rd(Op_rd),
        .Wb_valid(Wb_valid), .Wb_addr(Wb_addr), .Wb_data(Wb_data),
        .Rf_Addr1(Rf_Addr1), .Rf_Addr2(Rf_Addr2), .Rf_Addr3(Rf_Addr3),
        .Rf_Regwrite(Rf_Regwrite), .Rf_Inputs(Rf_Inputs),
        .Rf_RD1(Rf_RD1), .Rf_RD2(Rf_RD2)
    );

    always #5 Clk = ~Clk;

    // Registered-read register file: a read sampled with a write to the same index returns the old value.
    always @(posedge Clk) begin
        Rf_RD1 <= (Rf_Addr1 == 0) ? '0 : rf_mem[Rf_Addr1];
        Rf_RD2 <= (Rf_Addr2 == 0) ? '0 : rf_mem[Rf_Addr2];
        if (Rf_Regwrite) rf_mem[Rf_Addr3] <= Rf_Inputs;
    end

    function automatic logic [31:0] enc(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic tick();
        @(posedge Clk);
        if (Wb_valid && Wb_addr != 0) arch[Wb_addr] = Wb_data;
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Instr_valid = 0; Instr = '0; Op_ready = 0; Wb_valid = 0; Wb_addr = '0; Wb_data = '0;
        for (int i = 0; i < D; i++) arch[i] = '0;
        #2 Rst = 1'b0;
        tick(); tick();
        total++;
        if ({Instr_ready, Op_valid, Op_A, Op_B, Op_rd, Rf_Addr1, Rf_Addr2} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%0b ov=%0b A=%h B=%h rd=%0d a1=%0d a2=%0d, required all 0",
                     Instr_ready, Op_valid, Op_A, Op_B, Op_rd, Rf_Addr1, Rf_Addr2);
        end
        Rst = 1'b1;
        #1;
        total++;
        if (Instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %0b, required 1", Instr_ready);
        end
        tick();
    endtask

    task automatic test_preload();
        logic [W-1:0] v;
        for (int r = 1; r < D; r++) begin
            v = (r == 5) ? 32'd50 : (r == 6) ? 32'd60 : $urandom;
            Wb_valid = 1; Wb_addr = AW'(r); Wb_data = v;
            #1;
            total++;
            if ({Rf_Regwrite, Rf_Addr3, Rf_Inputs} !== {1'b1, AW'(r), v}) begin
                bad++;
                $display("FAIL preload_write x%0d: we=%0b a=%0d d=%h, required 1 %0d %h",
                         r, Rf_Regwrite, Rf_Addr3, Rf_Inputs, r, v);
            end
            tick();
        end
        Wb_valid = 0;
        tick();
    endtask

    // One instruction with optional writebacks in the first two cycles after acceptance.
    task automatic run_op(input string name, input logic [31:0] ins,
                          input logic wv0, input logic [AW-1:0] wa0, input logic [W-1:0] wd0,
                          input logic wv1, input logic [AW-1:0] wa1, input logic [W-1:0] wd1);
        logic [4:0] rs1, rs2, rd;
        logic conflict, got, exp_rw;
        int lat, exp_lat;
        rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
        conflict = (wv0 && wa0 != 0 && ((wa0 == rs1 && rs1 != 0) || (wa0 == rs2 && rs2 != 0))) ||
                   (wv1 && wa1 != 0 && ((wa1 == rs1 && rs1 != 0) || (wa1 == rs2 && rs2 != 0)));
`ifdef WB_BYPASS_EN
        exp_lat = 2;
`else
        exp_lat = conflict ? 4 : 2;
`endif
        total++;
        if (Instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s idle_ready: got %0b, required 1", name, Instr_ready);
        end
        Instr = ins; Instr_valid = 1;
        tick();
        Instr_valid = 0; Instr = $urandom;
        lat = 0; got = 0;
        for (int k = 0; k < 16 && !got; k++) begin
            if (k == 0) begin Wb_valid = wv0; Wb_addr = wa0; Wb_data = wd0; end
            else if (k == 1) begin Wb_valid = wv1; Wb_addr = wa1; Wb_data = wd1; end
            else Wb_valid = 0;
            if (Wb_valid) begin
                #1;
                exp_rw = (Wb_addr != 0);
                total++;
                if ({Rf_Regwrite, Rf_Addr3, Rf_Inputs} !== {exp_rw, Wb_addr, Wb_data}) begin
                    bad++;
                    $display("FAIL %s wb_port: we=%0b a=%0d d=%h, required %0b %0d %h",
                             name, Rf_Regwrite, Rf_Addr3, Rf_Inputs, exp_rw, Wb_addr, Wb_data);
                end
            end
            tick();
            lat++;
            if (Op_valid) got = 1;
        end
        Wb_valid = 0;
        total++;
        if (!got || lat != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d (valid=%0b), required %0d", name, lat, got, exp_lat);
        end
        total++;
        if (Op_A !== ((rs1 == 0) ? '0 : arch[rs1])) begin
            bad++;
            $display("FAIL %s op_a: got %h, required %h", name, Op_A, (rs1 == 0) ? '0 : arch[rs1]);
        end
        total++;
        if (Op_B !== ((rs2 == 0) ? '0 : arch[rs2])) begin
            bad++;
            $display("FAIL %s op_b: got %h, required %h", name, Op_B, (rs2 == 0) ? '0 : arch[rs2]);
        end
        total++;
        if (Op_rd !== rd) begin
            bad++;
            $display("FAIL %s op_rd: got %0d, required %0d", name, Op_rd, rd);
        end
        Op_ready = 1;
        tick();
        Op_ready = 0;
        total++;
        if ({Op_valid, Instr_ready} !== 2'b01) begin
            bad++;
            $display("FAIL %s release: valid=%0b ready=%0b, required 0 1", name, Op_valid, Instr_ready);
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!Op_valid && n < 16) begin tick(); n++; end
        total++;
        if (!Op_valid) begin
            bad++;
            $display("FAIL %s wait_valid: Op_valid still 0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic test_basic();
        run_op("basic", 32'h006283B3, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_a, exp_b;
        Instr = enc(5, 6, 7); Instr_valid = 1;
        tick();
        Instr_valid = 0;
        wait_valid("bp");
        exp_a = arch[5]; exp_b = arch[6];
        for (int i = 0; i < 5; i++) begin
            Wb_valid = (i == 0); Wb_addr = 5'd5; Wb_data = 32'h77;
            Instr_valid = 1; Instr = enc(1, 2, 3);
            tick();
            total++;
            if ({Op_valid, Instr_ready, Op_A, Op_B, Op_rd} !== {1'b1, 1'b0, exp_a, exp_b, 5'd7}) begin
                bad++;
                $display("FAIL bp_hold cyc%0d: v=%0b rdy=%0b A=%h B=%h rd=%0d, required 1 0 %h %h 7",
                         i, Op_valid, Instr_ready, Op_A, Op_B, Op_rd, exp_a, exp_b);
            end
        end
        Wb_valid = 0; Instr_valid = 0;
        Op_ready = 1;
        tick();
        Op_ready = 0;
        total++;
        if ({Op_valid, Instr_ready} !== 2'b01) begin
            bad++;
            $display("FAIL bp_release: valid=%0b ready=%0b, required 0 1", Op_valid, Instr_ready);
        end
        total++;
        if (arch[5] !== 32'h77) begin
            bad++;
            $display("FAIL bp_hold_write: model x5=%h, required 00000077", arch[5]);
        end
    endtask

    task automatic test_x0();
        run_op("x0", enc(0, 6, 9), 1, 5'd0, 32'hDEAD, 0, '0, '0);
    endtask

    task automatic test_conflicts();
        run_op("issue_conflict", 32'h006283B3, 1, 5'd5, 32'h1234, 0, '0, '0);
        run_op("double_rs2", 32'h006283B3, 1, 5'd6, 32'h1111, 1, 5'd6, 32'h2222);
        run_op("wait_conflict", enc(5, 5, 4), 0, '0, '0, 1, 5'd5, 32'hCAFE);
    endtask

    task automatic test_random();
        logic [4:0] rs1, rs2, rd, wa [2];
        logic wv [2];
        logic [W-1:0] wd [2];
        for (int n = 0; n < 40; n++) begin
            rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31)); rd = 5'($urandom);
            for (int k = 0; k < 2; k++) begin
                wv[k] = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 3))
                    0: wa[k] = rs1;
                    1: wa[k] = rs2;
                    2: wa[k] = 5'd0;
                    default: wa[k] = 5'($urandom);
                endcase
                wd[k] = $urandom;
            end
            run_op("random", enc(rs1, rs2, rd), wv[0], wa[0], wd[0], wv[1], wa[1], wd[1]);
        end
    endtask

    task automatic test_reset_hold();
        Instr = enc(5, 6, 7); Instr_valid = 1;
        tick();
        Instr_valid = 0;
        wait_valid("rst_hold");
        #3 Rst = 1'b0;
        #1;
        total++;
        if ({Op_valid, Op_A, Op_B, Op_rd, Instr_ready, Rf_Addr1, Rf_Addr2} !== '0) begin
            bad++;
            $display("FAIL rst_hold_clear: v=%0b A=%h B=%h rd=%0d rdy=%0b a1=%0d a2=%0d, required all 0",
                     Op_valid, Op_A, Op_B, Op_rd, Instr_ready, Rf_Addr1, Rf_Addr2);
        end
        #2 Rst = 1'b1;
        tick();
        total++;
        if ({Op_valid, Instr_ready} !== 2'b01) begin
            bad++;
            $display("FAIL rst_hold_idle: valid=%0b ready=%0b, required 0 1", Op_valid, Instr_ready);
        end
        run_op("after_reset", enc(6, 5, 8), 0, '0, '0, 0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_preload();
        test_basic();
        test_backpressure();
        test_x0();
        test_conflicts();
        test_random();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
